// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch stage.
//   fetch_state_e : fetch FSM states
//   fetch_entry_t : one prefetched instruction with its PC tag
package fetch_pkg;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned INSTR_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        REDIRECT = 2'd2,
        FAULT    = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch_entry_t.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (clears storage too)
//   i_push, i_data    write an entry (accepted when not full, or when full with a pop)
//   i_pop             consume the head (ignored when empty)
//   i_flush           empty the FIFO; wins over push and pop
//   o_data            head entry
//   o_full, o_empty   occupancy flags
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  fetch_entry_t i_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W = IDX_W + 1;

    fetch_entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic                   w_do_push;
    logic                   w_do_pop;

    // Extra pointer bit distinguishes a wrapped (full) FIFO from an empty one.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                       (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // When full, a same-cycle pop frees the head slot that the push overwrites.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[IDX_W-1:0]];

    // Pointer and storage update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[IDX_W-1:0]] <= i_data;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads the 16-bit instruction RAM,
// buffers {pc, instr} in a prefetch FIFO and hands it to decode over valid/ready.
// Widths ADDR_W / INSTR_W come from fetch_pkg.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   run                            allow issuing new RAM reads
//   redirect_valid, redirect_pc    load a new PC and flush the FIFO
//   mem_address, mem_read_enable   RAM address (= pc) and read strobe
//   mem_data_out                   RAM read data, valid with the strobe
//   instr_valid, instr, instr_pc   FIFO head presented to decode
//   instr_ready                    decode accepts the head
//   fetch_fault                    sticky out-of-range redirect flag
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = 2048,
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  mem_address,
    output logic               mem_read_enable,
    input  logic [INSTR_W-1:0] mem_data_out,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    output logic               fetch_fault
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic              r_fault;

    logic              w_redir_oor;
    logic              w_redir_take;
    logic              w_flush;
    logic              w_full;
    logic              w_empty;
    logic              w_space;
    logic              w_pop;
    fetch_entry_t      w_push_entry;
    fetch_entry_t      w_head;

    // Redirect classification: out-of-range faults from any state,
    // an in-range target is ignored once faulted.
    assign w_redir_oor  = redirect_valid && (32'(redirect_pc) >= MEM_WORDS);
    assign w_redir_take = redirect_valid && !w_redir_oor && (r_state != FAULT);
    assign w_flush      = w_redir_oor || w_redir_take;

    // Fetch rule: a slot is available if not full or the head leaves this edge.
    assign w_space         = !w_full || (instr_valid && instr_ready);
    assign mem_read_enable = (r_state == FETCH) && run && !redirect_valid && w_space;
    // A flush discards the head, so it is not delivered.
    assign w_pop           = instr_valid && instr_ready && !w_flush;

    assign w_push_entry.pc    = r_pc;
    assign w_push_entry.instr = mem_data_out;

    assign mem_address = r_pc;
    assign fetch_fault = r_fault;
    assign instr_valid = !w_empty;
    assign instr       = w_head.instr;
    assign instr_pc    = w_head.pc;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; redirects take priority over run
    always_comb begin
        w_state_next = r_state;
        if (w_redir_oor) begin
            w_state_next = FAULT;
        end else if (w_redir_take) begin
            w_state_next = REDIRECT;
        end else begin
            case (r_state)
                IDLE:     w_state_next = run ? FETCH : IDLE;
                FETCH:    w_state_next = run ? FETCH : IDLE;
                REDIRECT: w_state_next = run ? FETCH : IDLE;
                FAULT:    w_state_next = FAULT;
                default:  w_state_next = IDLE;
            endcase
        end
    end

    // PC: redirect load, otherwise advance (with wrap) on every issued read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= ADDR_W'(RESET_PC);
        end else if (w_redir_take) begin
            r_pc <= redirect_pc;
        end else if (mem_read_enable) begin
            r_pc <= (r_pc == ADDR_W'(MEM_WORDS - 1)) ? '0 : r_pc + ADDR_W'(1);
        end
    end

    // Sticky fault flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (w_redir_oor) begin
            r_fault <= 1'b1;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (mem_read_enable),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic, each cycle
// compared with a queue-based reference model of the fetch stage.
module tb_instr_fetch;

    localparam int DEPTH = 2;
    localparam int MEMW  = 2048;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic [11:0] mem_address;
    logic        mem_read_enable;
    logic [15:0] mem_data_out;
    logic        instr_valid;
    logic [15:0] instr;
    logic [11:0] instr_pc;
    logic        instr_ready;
    logic        fetch_fault;

    always #5 clk = ~clk;

    // Behavioural RAM: mem[i] = A000 + i
    assign mem_data_out = 16'hA000 + {4'h0, mem_address};

    instr_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .run             (run),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .mem_address     (mem_address),
        .mem_read_enable (mem_read_enable),
        .mem_data_out    (mem_data_out),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .fetch_fault     (fetch_fault)
    );

    // Reference model state
    int unsigned m_pc;
    logic [27:0] m_q[$];
    bit          m_fetch;
    bit          m_fault;
    bit          m_clean;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [11:0] got_pc[$];
    logic [15:0] got_in[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 0;
        m_q.delete();
        m_fetch = 1'b0;
        m_fault = 1'b0;
        m_clean = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare against model, advance model and clock.
    task automatic cyc(input bit run_i, input bit ready_i, input bit rv_i,
                       input logic [11:0] rpc_i, input bit rstn_i);
        bit exp_en;
        run            = run_i;
        instr_ready    = ready_i;
        redirect_valid = rv_i;
        redirect_pc    = rpc_i;
        rst_n          = rstn_i;
        #1;
        exp_en = m_fetch && run_i && !rv_i &&
                 ((m_q.size() < DEPTH) || ((m_q.size() > 0) && ready_i));
        chk("mem_read_enable", 32'(mem_read_enable), 32'(exp_en));
        chk("mem_address", 32'(mem_address), m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(m_q.size() > 0));
        chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
        if (m_q.size() > 0) begin
            chk("instr_pc", 32'(instr_pc), 32'(m_q[0][27:16]));
            chk("instr", 32'(instr), 32'(m_q[0][15:0]));
        end else if (m_clean) begin
            chk("instr_pc_rst", 32'(instr_pc), 32'(0));
            chk("instr_rst", 32'(instr), 32'(0));
        end
        if (rstn_i && !rv_i && instr_valid && ready_i) begin
            got_pc.push_back(instr_pc);
            got_in.push_back(instr);
        end
        // Model update at the edge
        if (!rstn_i) begin
            model_reset();
        end else if (rv_i && int'(rpc_i) >= MEMW) begin
            m_fault = 1'b1;
            m_q.delete();
            m_fetch = 1'b0;
        end else if (rv_i && !m_fault) begin
            m_pc = int'(rpc_i);
            m_q.delete();
            m_fetch = 1'b0;
        end else begin
            if (ready_i && m_q.size() > 0) void'(m_q.pop_front());
            if (exp_en) begin
                m_q.push_back({12'(m_pc), 16'(16'hA000 + m_pc)});
                m_pc    = (m_pc == MEMW - 1) ? 0 : m_pc + 1;
                m_clean = 1'b0;
            end
            m_fetch = !m_fault && run_i;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_got(input string tag, input int idx,
                           input logic [11:0] pc_e, input logic [15:0] in_e);
        chk({tag, "_pc"}, 32'(got_pc[idx]), 32'(pc_e));
        chk({tag, "_instr"}, 32'(got_in[idx]), 32'(in_e));
    endtask

    initial begin
        run = 0; redirect_valid = 0; redirect_pc = '0; instr_ready = 0; rst_n = 0;
        @(posedge clk);
        #1;
        model_reset();
        cyc(0, 0, 0, 12'h000, 0);

        // 1: free-running fetch with decode always ready
        got_pc.delete(); got_in.delete();
        repeat (6) cyc(1, 1, 0, 12'h000, 1);
        chk("p1_count", 32'(got_pc.size()), 32'(4));
        chk_got("p1_0", 0, 12'h000, 16'hA000);
        chk_got("p1_1", 1, 12'h001, 16'hA001);
        chk_got("p1_2", 2, 12'h002, 16'hA002);

        // 2: decode stalls, FIFO fills, then releases
        cyc(1, 0, 0, 12'h000, 0);
        got_pc.delete(); got_in.delete();
        repeat (7) cyc(1, 0, 0, 12'h000, 1);
        chk("p2_hold_en", 32'(mem_read_enable), 32'(0));
        chk("p2_hold_pc", 32'(mem_address), 32'(2));
        repeat (6) cyc(1, 1, 0, 12'h000, 1);
        chk("p2_count", 32'(got_pc.size()), 32'(6));
        for (int i = 0; i < 4; i++) chk_got("p2_seq", i, 12'(i), 16'(16'hA000 + i));

        // 3: redirect with a full FIFO
        repeat (2) cyc(1, 0, 0, 12'h000, 1);
        got_pc.delete(); got_in.delete();
        cyc(1, 1, 1, 12'h100, 1);
        chk("p3_flush_valid", 32'(instr_valid), 32'(0));
        repeat (5) cyc(1, 1, 0, 12'h000, 1);
        chk_got("p3_0", 0, 12'h100, 16'hA100);
        chk_got("p3_1", 1, 12'h101, 16'hA101);

        // 4: PC wrap at the top of memory
        got_pc.delete(); got_in.delete();
        cyc(1, 1, 1, 12'h7FE, 1);
        repeat (6) cyc(1, 1, 0, 12'h000, 1);
        chk_got("p4_0", 0, 12'h7FE, 16'hA7FE);
        chk_got("p4_1", 1, 12'h7FF, 16'hA7FF);
        chk_got("p4_2", 2, 12'h000, 16'hA000);
        chk_got("p4_3", 3, 12'h001, 16'hA001);

        // 5: out-of-range redirect, then an ignored valid redirect
        cyc(1, 0, 0, 12'h000, 1);
        cyc(1, 1, 1, 12'h900, 1);
        repeat (3) cyc(1, 1, 0, 12'h000, 1);
        chk("p5_fault", 32'(fetch_fault), 32'(1));
        chk("p5_valid", 32'(instr_valid), 32'(0));
        chk("p5_en", 32'(mem_read_enable), 32'(0));
        cyc(1, 1, 1, 12'h010, 1);
        repeat (3) cyc(1, 1, 0, 12'h000, 1);
        chk("p5_fault_held", 32'(fetch_fault), 32'(1));
        chk("p5_pc_held", 32'(mem_address), 32'(4));

        // 6: reset mid-stream with a full FIFO
        cyc(1, 1, 0, 12'h000, 0);
        repeat (4) cyc(1, 0, 0, 12'h000, 1);
        cyc(1, 0, 0, 12'h000, 0);
        chk("p6_valid", 32'(instr_valid), 32'(0));
        chk("p6_instr", 32'(instr), 32'(0));
        chk("p6_instr_pc", 32'(instr_pc), 32'(0));
        chk("p6_addr", 32'(mem_address), 32'(0));
        chk("p6_en", 32'(mem_read_enable), 32'(0));
        chk("p6_fault", 32'(fetch_fault), 32'(0));
        got_pc.delete(); got_in.delete();
        repeat (6) cyc(1, 1, 0, 12'h000, 1);
        chk_got("p6_0", 0, 12'h000, 16'hA000);
        chk_got("p6_1", 1, 12'h001, 16'hA001);

        // 7: random traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit          r_run, r_rdy, r_rv, r_rst;
            logic [11:0] r_pc;
            r_run = ($urandom_range(0, 9) != 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            r_rv  = ($urandom_range(0, 19) == 0);
            r_rst = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 99) < 85) r_pc = 12'($urandom_range(0, 2047));
            else                            r_pc = 12'($urandom_range(2048, 4095));
            if ($urandom_range(0, 9) == 0)  r_pc = 12'($urandom_range(2044, 2047));
            cyc(r_run, r_rdy, r_rv, r_pc, r_rst);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
